nanci_shearsort_ctrl: RTL and testbench
=======================================

Name: nanci_shearsort_ctrl

Overview:
- Global phase sequencer for the Nanci PE mesh.
- After a start request it pulses a memory-load phase, then runs the shearsort schedule: alternating snake row-sort and column-sort phases of odd-even transposition steps, ending with a final row sort.
- It then runs the compute phase and signals done.
- One instance drives the broadcast phase/step control inputs of every PE in the SQRT_N x SQRT_N mesh.

Parameters:
- SQRT_N, 4, mesh side length; values 0 and 1 are both treated as 1.
- SORT_CYCLES, 1, clock cycles per compare-exchange step (>=1).
- COMPUTE_CYCLES, 1, clock cycles in the compute phase (>=1).
- ROUNDS, localparam, $clog2(max(SQRT_N,1))+1; number of row-sort phases. Column-sort phases = ROUNDS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  start request, sampled only in IDLE.
- i_abort  in  1  synchronous abort; returns to IDLE.
- o_phase  out  3  current phase code (nanci_ctrl_pkg encoding).
- o_load  out  1  high during LOAD; PEs (re)load local memory.
- o_step_en  out  1  high on the last cycle of each sort step; PEs commit the compare-exchange on this cycle.
- o_step_odd  out  1  parity of the current step within its phase; 0 = even pairs, 1 = odd pairs.
- o_round  out  $clog2(ROUNDS+1)  index of the current row/column round, starting at 0.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset: state IDLE, all counters 0. All outputs 0, except o_phase = PH_IDLE.
- Reset mid-operation aborts immediately; no o_done is produced.
- FSM states and transitions:
  - IDLE: on i_start=1 and i_abort=0 at an edge, go to LOAD.
  - LOAD: lasts 1 cycle, then ROW with round=0.
  - ROW: lasts SQRT_N steps x SORT_CYCLES cycles. Then:
    - if round < ROUNDS-1, go to COL;
    - otherwise go to COMPUTE.
  - COL: lasts the same length as ROW. Then go to ROW with round+1.
  - COMPUTE: lasts COMPUTE_CYCLES cycles, then DONE.
  - DONE: lasts 1 cycle with o_done=1, then IDLE.
- Step timing:
  - Cycle counter cyc runs 0..SORT_CYCLES-1; step counter runs 0..SQRT_N-1.
  - o_step_en = (cyc == SORT_CYCLES-1) in ROW/COL, otherwise 0.
  - o_step_odd = step[0]. Step and cyc reset to 0 at every phase entry, so every phase starts even.
- o_round:
  - Increments on COL->ROW.
  - Holds through COMPUTE/DONE.
  - Cleared in IDLE.
- Total latency from the start-sampling edge: LOAD in cycle 1; o_done in cycle 2 + (2*ROUNDS-1)*SQRT_N*SORT_CYCLES + COMPUTE_CYCLES.
- i_start is ignored while busy; a request is not queued.
- i_start held high through DONE causes a new LOAD in the cycle after the DONE->IDLE transition's IDLE cycle. IDLE always lasts at least 1 cycle.
- i_abort:
  - In any non-IDLE state, the next state is IDLE and all counters clear.
  - In DONE, the o_done pulse in the current cycle stands.
  - Simultaneous i_start and i_abort in IDLE: abort wins, stay IDLE.
- All outputs are registered or decoded from state registers only; there are no combinational paths from inputs to outputs.

Decomposition:
- Package nanci_ctrl_pkg holds:
  - phase encoding: PH_IDLE=0, PH_LOAD=1, PH_ROW=2, PH_COL=3, PH_COMPUTE=4, PH_DONE=5;
  - the typedef phase_t;
  - the function rounds_f(sqrt_n).
- Sub-module nanci_step_timer contains the cyc and step counters, with inputs clear/enable and outputs step_en, step_odd, phase_last.
  - The FSM instantiates it for ROW/COL.
  - It reuses cyc as the COMPUTE_CYCLES counter.

Test Plan:
- Defaults (SQRT_N=4, SORT_CYCLES=1, COMPUTE_CYCLES=1), start pulse at edge 0:
  - o_load in cycle 1;
  - ROW 2-5, COL 6-9, ROW 10-13, COL 14-17, ROW 18-21;
  - COMPUTE 22; o_done in cycle 23 only; IDLE in 24.
- Same run: o_step_en high in each of cycles 2-21; o_step_odd pattern 0,1,0,1 per phase; o_round 0,0,1,1,2 across the five phases.
- SORT_CYCLES=3, SQRT_N=2, COMPUTE_CYCLES=2:
  - ROUNDS=2; o_step_en every third cycle;
  - o_done in cycle 2+3*2*3+2 = 22.
- SQRT_N=0: single ROW phase of one step, then COMPUTE; o_done in cycle 2+1+1 = 4; no COL phase ever seen.
- i_abort asserted in cycle 7 (COL): IDLE in cycle 8, o_busy=0, no o_done. A start in cycle 8 restarts with LOAD in cycle 9 and o_round=0.
- Async rst asserted mid-ROW between edges: outputs return to reset values before the next edge. i_start held high during busy/DONE gives exactly one IDLE cycle between runs.

Source files
------------

// File: rtl/nanci_ctrl_pkg.sv
// Shared phase encoding and sizing helpers for the Nanci mesh controller.
package nanci_ctrl_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_LOAD    = 3'd1,
        PH_ROW     = 3'd2,
        PH_COL     = 3'd3,
        PH_COMPUTE = 3'd4,
        PH_DONE    = 3'd5
    } phase_t;

    // Number of row-sort phases; a degenerate mesh side of 0 behaves as 1.
    function automatic int rounds_f(input int sqrt_n);
        int n;
        n = (sqrt_n < 1) ? 1 : sqrt_n;
        return $clog2(n) + 1;
    endfunction

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nanci_step_timer.sv
// Cycle/step counters for sort phases; cyc doubles as the compute-phase counter.
module nanci_step_timer import nanci_ctrl_pkg::*; #(
    parameter int STEPS          = 4,
    parameter int SORT_CYCLES    = 1,
    parameter int COMPUTE_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    input  logic compute_i,
    output logic step_en_o,
    output logic step_odd_o,
    output logic phase_last_o
);
    localparam int CW = $clog2(max_f(SORT_CYCLES, COMPUTE_CYCLES)) + 1;
    localparam int SW = $clog2(STEPS) + 1;

    logic [CW-1:0] cyc_q, cyc_d;
    logic [SW-1:0] step_q, step_d;
    logic          cyc_last;
    logic          step_last;

    assign cyc_last  = compute_i ? (cyc_q == CW'(COMPUTE_CYCLES - 1))
                                 : (cyc_q == CW'(SORT_CYCLES - 1));
    assign step_last = (step_q == SW'(STEPS - 1));

    always_comb begin
        cyc_d  = cyc_q;
        step_d = step_q;
        if (clear_i) begin
            cyc_d  = '0;
            step_d = '0;
        end else if (enable_i) begin
            if (cyc_last) begin
                cyc_d = '0;
                if (!compute_i) begin
                    step_d = step_last ? '0 : step_q + SW'(1);
                end
            end else begin
                cyc_d = cyc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q  <= '0;
            step_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            step_q <= step_d;
        end
    end

    assign step_en_o    = enable_i && !compute_i && cyc_last;
    assign step_odd_o   = step_q[0];
    assign phase_last_o = enable_i && cyc_last && (compute_i || step_last);

endmodule

// File: rtl/nanci_shearsort_ctrl.sv
// Global phase sequencer: LOAD, alternating snake row/column sorts, COMPUTE, DONE.
module nanci_shearsort_ctrl import nanci_ctrl_pkg::*; #(
    parameter  int SQRT_N         = 4,
    parameter  int SORT_CYCLES    = 1,
    parameter  int COMPUTE_CYCLES = 1,
    localparam int ROUNDS         = rounds_f(SQRT_N),
    localparam int RW             = $clog2(ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_abort,
    output logic [2:0]    o_phase,
    output logic          o_load,
    output logic          o_step_en,
    output logic          o_step_odd,
    output logic [RW-1:0] o_round,
    output logic          o_busy,
    output logic          o_done
);
    localparam int SN = (SQRT_N < 1) ? 1 : SQRT_N;

    phase_t        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic          timer_clear, timer_en, timer_compute;
    logic          step_en, step_odd, phase_last;

    assign timer_clear   = (state_d != state_q);
    assign timer_compute = (state_q == PH_COMPUTE);
    assign timer_en      = (state_q == PH_ROW) || (state_q == PH_COL) || timer_compute;

    nanci_step_timer #(
        .STEPS          (SN),
        .SORT_CYCLES    (SORT_CYCLES),
        .COMPUTE_CYCLES (COMPUTE_CYCLES)
    ) u_timer (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (timer_clear),
        .enable_i     (timer_en),
        .compute_i    (timer_compute),
        .step_en_o    (step_en),
        .step_odd_o   (step_odd),
        .phase_last_o (phase_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PH_IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            PH_IDLE:    if (i_start && !i_abort) state_d = PH_LOAD;
            PH_LOAD:    state_d = PH_ROW;
            PH_ROW:     if (phase_last) state_d = (int'(round_q) < ROUNDS - 1) ? PH_COL : PH_COMPUTE;
            PH_COL:     if (phase_last) state_d = PH_ROW;
            PH_COMPUTE: if (phase_last) state_d = PH_DONE;
            PH_DONE:    state_d = PH_IDLE;
            default:    state_d = PH_IDLE;
        endcase
        if (state_q != PH_IDLE && i_abort) begin
            state_d = PH_IDLE;
        end
        // Round only advances on COL->ROW and is dropped whenever we head back to IDLE.
        if (state_d == PH_IDLE) begin
            round_d = '0;
        end else if (state_q == PH_COL && state_d == PH_ROW) begin
            round_d = round_q + RW'(1);
        end
    end

    always_comb begin
        o_phase    = state_q;
        o_load     = (state_q == PH_LOAD);
        o_step_en  = step_en;
        o_step_odd = step_odd;
        o_round    = round_q;
        o_busy     = (state_q != PH_IDLE);
        o_done     = (state_q == PH_DONE);
    end

endmodule

// File: tb/tb_nanci_shearsort_ctrl.sv
// Scoreboard bench: three controller configurations checked cycle by cycle.
module tb_nanci_shearsort_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start0, abort0, start1, abort1, start2, abort2;

    logic [2:0] ph0, ph1, ph2;
    logic       load0, load1, load2, sen0, sen1, sen2, odd0, odd1, odd2;
    logic       busy0, busy1, busy2, done0, done1, done2;
    logic [1:0] rnd0, rnd1;
    logic [0:0] rnd2;

    int tests_run = 0;
    int failed    = 0;
    int ncyc      = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    always #5 clk = ~clk;

    nanci_shearsort_ctrl #(.SQRT_N(4), .SORT_CYCLES(1), .COMPUTE_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .i_start(start0), .i_abort(abort0),
        .o_phase(ph0), .o_load(load0), .o_step_en(sen0), .o_step_odd(odd0),
        .o_round(rnd0), .o_busy(busy0), .o_done(done0));

    nanci_shearsort_ctrl #(.SQRT_N(2), .SORT_CYCLES(3), .COMPUTE_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .i_abort(abort1),
        .o_phase(ph1), .o_load(load1), .o_step_en(sen1), .o_step_odd(odd1),
        .o_round(rnd1), .o_busy(busy1), .o_done(done1));

    nanci_shearsort_ctrl #(.SQRT_N(0), .SORT_CYCLES(1), .COMPUTE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .i_start(start2), .i_abort(abort2),
        .o_phase(ph2), .o_load(load2), .o_step_en(sen2), .o_step_odd(odd2),
        .o_round(rnd2), .o_busy(busy2), .o_done(done2));

    // Hand-chosen configuration constants: side, sort cycles, compute cycles, rounds.
    function automatic void cfg(input int inst, output int sn, output int sc, output int cc, output int r);
        case (inst)
            0:       begin sn = 4; sc = 1; cc = 1; r = 3; end
            1:       begin sn = 2; sc = 3; cc = 2; r = 2; end
            default: begin sn = 1; sc = 1; cc = 1; r = 1; end
        endcase
    endfunction

    function automatic int done_cycle(input int inst);
        int sn, sc, cc, r;
        cfg(inst, sn, sc, cc, r);
        return 2 + (2 * r - 1) * sn * sc + cc;
    endfunction

    // Expected {phase, load, step_en, odd, round[1:0], busy, done} t cycles after the start edge.
    function automatic logic [9:0] exp_vec(input int inst, input int t);
        int sn, sc, cc, r, l, p, w, d;
        logic [2:0] ph;
        logic ld, se, od, bs, dn;
        logic [1:0] rd;
        cfg(inst, sn, sc, cc, r);
        l = sn * sc;
        p = 2 * r - 1;
        d = done_cycle(inst);
        ph = 3'd0; ld = 0; se = 0; od = 0; bs = 0; dn = 0; rd = 2'd0;
        if (t == 1) begin
            ph = 3'd1; ld = 1; bs = 1;
        end else if (t >= 2 && t < 2 + p * l) begin
            w  = (t - 2) % l;
            ph = (((t - 2) / l) % 2 == 0) ? 3'd2 : 3'd3;
            rd = 2'((t - 2) / l / 2);
            se = ((w % sc) == sc - 1);
            od = ((w / sc) % 2 == 1);
            bs = 1;
        end else if (t >= 2 + p * l && t < d) begin
            ph = 3'd4; rd = 2'(r - 1); bs = 1;
        end else if (t == d) begin
            ph = 3'd5; rd = 2'(r - 1); bs = 1; dn = 1;
        end
        return {ph, ld, se, od, rd, bs, dn};
    endfunction

    task automatic check(input int inst, input logic [9:0] act, input logic [9:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL dut%0d outputs at cycle %0d: got %b expected %b (phase,load,step_en,odd,round,busy,done)",
                     inst, ncyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (q0.size() > 0) check(0, {ph0, load0, sen0, odd0, rnd0, busy0, done0}, q0.pop_front());
        if (q1.size() > 0) check(1, {ph1, load1, sen1, odd1, rnd1, busy1, done1}, q1.pop_front());
        if (q2.size() > 0) check(2, {ph2, load2, sen2, odd2, 1'b0, rnd2, busy2, done2}, q2.pop_front());
    end

    task automatic push(input int inst, input logic [9:0] v);
        case (inst)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic set_in(input int inst, input logic s, input logic a);
        case (inst)
            0:       begin start0 = s; abort0 = a; end
            1:       begin start1 = s; abort1 = a; end
            default: begin start2 = s; abort2 = a; end
        endcase
    endtask

    // Called just after an edge; t=0 is the cycle whose closing edge samples start.
    task automatic run(input int inst, input int nc, input int abort_t, input int rst_t, input bit hold);
        int d;
        logic [9:0] e;
        d = done_cycle(inst);
        for (int t = 0; t <= nc; t++) begin
            set_in(inst, (t == 0) || (hold && t < nc), t == abort_t);
            if (t == rst_t) begin
                rst = 1'b1;
                #1;
            end else begin
                rst = 1'b0;
            end
            if ((abort_t >= 0 && t > abort_t) || (rst_t >= 0 && t >= rst_t)) e = '0;
            else e = exp_vec(inst, hold ? (t % (d + 1)) : t);
            push(inst, e);
            @(posedge clk);
            #1;
        end
        set_in(inst, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start0 = 0; abort0 = 0; start1 = 0; abort1 = 0; start2 = 0; abort2 = 0;
        push(0, '0); push(1, '0); push(2, '0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(0, 26, -1, -1, 1'b0);
        run(0, 7, 7, -1, 1'b0);
        run(0, 26, -1, -1, 1'b0);
        run(0, 3, 0, -1, 1'b0);
        run(0, 6, -1, 3, 1'b0);
        run(0, 48, -1, -1, 1'b1);
        run(1, 25, -1, -1, 1'b0);
        run(2, 7, -1, -1, 1'b0);

        @(negedge clk);
        #1;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            tests_run++;
            failed++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
